// File: rtl/video_ram_arbiter_if.sv
// Video RAM arbiter bus: CPU request/ack port plus the single-port RAM port.
// The arbiter takes the slave side; the CPU/RAM environment takes the master side.
interface video_ram_arbiter_if;
    // CPU side
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    // RAM side (synchronous RAM, 1-cycle read latency)
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/video_ram_arbiter.sv
// Video RAM arbiter: shares a single-port video RAM between the display
// fetch (absolute priority, fixed slots every 8 pixels) and a CPU port.
// Display bytes are serialised MSB-first onto the pixel output.
module video_ram_arbiter #(
    parameter int X_START        = 49,
    parameter int Y_START        = 36,
    parameter int ACTIVE_LINES   = 192,
    parameter int BYTES_PER_LINE = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          hCounter,
    input  logic [8:0]          vCounter,
    video_ram_arbiter_if.slave  bus,
    output logic                pixel
);

    localparam logic [9:0] SLOT_FIRST = 10'(X_START - 2);
    localparam logic [9:0] SLOT_LAST  = 10'(X_START - 2 + 8 * (BYTES_PER_LINE - 1));
    localparam logic [8:0] LINE_FIRST = 9'(Y_START);
    localparam logic [8:0] LINE_LAST  = 9'(Y_START + ACTIVE_LINES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    // Display slot decode; slots are 8 apart, so alignment is a low-bit match.
    function automatic logic is_slot(input logic [9:0] h, input logic [8:0] v);
        return (v >= LINE_FIRST) && (v <= LINE_LAST) &&
               (h >= SLOT_FIRST) && (h <= SLOT_LAST) &&
               (h[2:0] == SLOT_FIRST[2:0]);
    endfunction

    state_t      state;
    logic        rd_l;
    logic        ack_q;
    logic [7:0]  rdata_q;

    logic        mem_en_q;
    logic        mem_we_q;
    logic [12:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;

    logic [12:0] fetch_addr;
    logic        slot_d;
    logic [7:0]  shreg;

    logic        slot_now;
    logic        slot_next;
    logic        go;
    logic        frame_start;

    assign slot_now    = is_slot({2'b00, hCounter}, vCounter);
    // Line changes only at the 255->0 wrap where no slot exists, so the
    // next cycle's slot can be decoded on the current line.
    assign slot_next   = is_slot({2'b00, hCounter} + 10'd1, vCounter);
    assign go          = (state == IDLE) && bus.cpu_req && !slot_next;
    assign frame_start = (hCounter == 8'd0) && (vCounter == 9'd0);

    // CPU access FSM: IDLE -> ACCESS -> ACK, registered ack and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_l    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (go) begin
                        state <= ACCESS;
                        rd_l  <= !bus.cpu_we;
                    end
                end
                ACCESS: begin
                    state <= ACK;
                    ack_q <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    if (rd_l) begin
                        rdata_q <= bus.mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM port registers: loaded one cycle ahead for the display slot or the
    // CPU access that will own the bus in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (slot_next) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= fetch_addr;
            mem_wdata_q <= '0;
        end else if (go) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.cpu_we;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end
    end

    // Display fetch address and pixel shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr <= '0;
            slot_d     <= 1'b0;
            shreg      <= '0;
        end else begin
            if (frame_start) begin
                fetch_addr <= '0;
            end else if (slot_now) begin
                fetch_addr <= fetch_addr + 13'd1;
            end
            slot_d <= slot_now;
            if (slot_d) begin
                shreg <= bus.mem_rdata;
            end else begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

    assign pixel         = shreg[7];
    assign bus.cpu_ack   = ack_q;
    // RAM data arrives in the ACK cycle, so it is forwarded there and held after.
    assign bus.cpu_rdata = (ack_q && rd_l) ? bus.mem_rdata : rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Directed self-checking bench for video_ram_arbiter: drives the sync
// counters, models the RAM, and checks display fetch, pixels and CPU port.
module tb_video_ram_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] hc;
    logic [8:0] vc;
    logic       pixel;

    video_ram_arbiter_if bus ();

    video_ram_arbiter #(
        .X_START(49),
        .Y_START(36),
        .ACTIVE_LINES(192),
        .BYTES_PER_LINE(24)
    ) dut (
        .clk(clk),
        .reset(rst),
        .hCounter(hc),
        .vCounter(vc),
        .bus(bus),
        .pixel(pixel)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  ram [8192];
    logic [12:0] exp_fetch = '0;
    logic [12:0] last_addr = '0;
    int          disp_reads = 0;
    logic        rst_prev = 1'b1;
    logic        a5_pix [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Independent slot list for the default geometry.
    function automatic logic tb_slot(input logic [7:0] h, input logic [8:0] v);
        if (v < 9'd36 || v > 9'd227) return 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (int'(h) == 47 + 8 * k) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Every display slot must own the RAM as a read of the next fetch address.
    always @(negedge clk) begin
        logic slot;
        slot = tb_slot(hc, vc);
        if (slot && !rst_prev) begin
            check("disp_en", 32'(bus.mem_en), 32'd1);
            check("disp_we", 32'(bus.mem_we), 32'd0);
            check("disp_addr", 32'(bus.mem_addr), 32'(exp_fetch));
            disp_reads++;
            last_addr = exp_fetch;
        end
        if (rst || (hc == 8'd0 && vc == 9'd0)) exp_fetch = '0;
        else if (slot) exp_fetch = exp_fetch + 13'd1;
        rst_prev = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (hc == 8'd255) begin
            hc = 8'd0;
            vc = (vc == 9'd312) ? 9'd0 : vc + 9'd1;
        end else begin
            hc = hc + 8'd1;
        end
        #1;
    endtask

    task automatic jump(input logic [8:0] v, input logic [7:0] h);
        @(posedge clk);
        #1;
        vc = v;
        hc = h;
        #1;
    endtask

    task automatic run_line(input int v);
        jump(9'(v), 8'd44);
        for (int s = 0; s < 196; s++) begin
            step();
            if (v == 36 && hc == 8'd47) begin
                check("l36_mem_en", 32'(bus.mem_en), 32'd1);
                check("l36_addr0", 32'(bus.mem_addr), 32'd0);
            end
            if (v == 36 && hc >= 8'd49 && hc <= 8'd56)
                check("l36_pixel", 32'(pixel), 32'(a5_pix[int'(hc) - 49]));
        end
    endtask

    task automatic frame_wrap();
        jump(9'd312, 8'd254);
        step();
        step();
    endtask

    initial begin
        logic [7:0]  b;
        logic [12:0] disp_addr;
        int          acks;
        int          last_ack;

        for (int i = 0; i < 8192; i++) ram[i] = 8'(i * 37 + 11);
        ram[0] = 8'hA5;

        rst = 1'b1;
        hc = 8'd0;
        vc = 9'd0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;

        // Reset state
        step();
        step();
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        rst = 1'b0;

        // Full frame of display fetches, no CPU traffic
        disp_reads = 0;
        for (int v = 36; v <= 227; v++) run_line(v);
        check("frame_reads", 32'(disp_reads), 32'd4608);
        check("frame_last_addr", 32'(last_addr), 32'd4607);

        // Next frame starts again from address 0
        frame_wrap();
        run_line(36);

        // Lines just outside the active area
        jump(9'd35, 8'd44);
        step(); step(); step();
        check("l35_mem_en", 32'(bus.mem_en), 32'd0);
        jump(9'd228, 8'd44);
        step(); step(); step();
        check("l228_mem_en", 32'(bus.mem_en), 32'd0);
        step(); step(); step();
        check("l228_pixel", 32'(pixel), 32'd0);

        // CPU write 0x3C to 0x0100, req at hCounter 10 on line 100
        jump(9'd100, 8'd8);
        step();
        step();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 13'h0100;
        bus.cpu_wdata = 8'h3C;
        step();
        check("wr_mem_en", 32'(bus.mem_en), 32'd1);
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h0100);
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
        check("wr_ack_early", 32'(bus.cpu_ack), 32'd0);
        step();
        check("wr_ack", 32'(bus.cpu_ack), 32'd1);
        check("wr_bus_idle", 32'(bus.mem_en), 32'd0);
        bus.cpu_req = 1'b0;
        step();
        check("wr_ack_pulse", 32'(bus.cpu_ack), 32'd0);

        // CPU read at hCounter 54 on line 40; 55 is display slot 1
        jump(9'd40, 8'd50);
        step(); step(); step(); step();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 13'h0100;
        step();
        disp_addr = exp_fetch;
        b = ram[disp_addr];
        check("rd_slot_we", 32'(bus.mem_we), 32'd0);
        check("rd_slot_addr", 32'(bus.mem_addr), 32'(disp_addr));
        check("rd_slot_ack", 32'(bus.cpu_ack), 32'd0);
        step();
        check("rd_access_en", 32'(bus.mem_en), 32'd1);
        check("rd_access_we", 32'(bus.mem_we), 32'd0);
        check("rd_access_addr", 32'(bus.mem_addr), 32'h0100);
        step();
        check("rd_ack", 32'(bus.cpu_ack), 32'd1);
        check("rd_data", 32'(bus.cpu_rdata), 32'h3C);
        check("rd_pix", 32'(pixel), 32'(b[7]));
        bus.cpu_req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            check("rd_pix", 32'(pixel), 32'(b[7 - i]));
            if (i == 1) begin
                check("rd_ack_pulse", 32'(bus.cpu_ack), 32'd0);
                check("rd_data_held", 32'(bus.cpu_rdata), 32'h3C);
            end
        end

        // Back-to-back reads with req held across several slots on line 60
        jump(9'd60, 8'd38);
        step();
        step();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 13'h0100;
        acks = 0;
        last_ack = -100;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.cpu_ack === 1'b1) begin
                acks++;
                check("b2b_data", 32'(bus.cpu_rdata), 32'h3C);
                check("b2b_gap", 32'((int'(hc) - last_ack) >= 3), 32'd1);
                last_ack = int'(hc);
            end
        end
        check("b2b_ack_count", 32'(acks), 32'd12);
        bus.cpu_req = 1'b0;
        step();
        check("b2b_tail_ack", 32'(bus.cpu_ack), 32'd1);
        step();
        check("b2b_tail_idle", 32'(bus.cpu_ack), 32'd0);

        // Reset while the FSM is in ACCESS
        jump(9'd120, 8'd8);
        step();
        step();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 13'h0200;
        bus.cpu_wdata = 8'h77;
        step();
        check("abort_in_access", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        step();
        check("abort_ack", 32'(bus.cpu_ack), 32'd0);
        check("abort_mem_en", 32'(bus.mem_en), 32'd0);
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("abort_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("abort_pixel", 32'(pixel), 32'd0);
        rst = 1'b0;
        step();
        check("abort_no_ack", 32'(bus.cpu_ack), 32'd0);

        // Normal operation on the next frame
        frame_wrap();
        run_line(36);
        jump(9'd37, 8'd8);
        step();
        step();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 13'h0100;
        step();
        check("post_rst_ack_early", 32'(bus.cpu_ack), 32'd0);
        step();
        check("post_rst_ack", 32'(bus.cpu_ack), 32'd1);
        check("post_rst_rdata", 32'(bus.cpu_rdata), 32'h3C);
        bus.cpu_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 Parameter X_START, default 49, hCounter value of the first visible pixel of a line.
REQ-002 Parameter Y_START, default 36, vCounter value of the first active line.
REQ-003 Parameter ACTIVE_LINES, default 192, number of active lines.
REQ-004 Parameter BYTES_PER_LINE, default 24, display bytes fetched per active line (8 pixels each).
REQ-005 clk  in  1  single clock, 4 MHz, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 hCounter  in  8  horizontal position from the sync generator, 0..255, increments every clk.
REQ-008 vCounter  in  9  line number from the sync generator, 0..312, increments when hCounter wraps 255->0.
REQ-009 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-010 cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-011 cpu_addr  in  13  CPU video RAM byte address.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_ack  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  8  read data, valid in the cpu_ack cycle, held until the next read completes.
REQ-015 mem_en  out  1  RAM enable; RAM is single-port, synchronous, 1-cycle read latency.
REQ-016 mem_we  out  1  RAM write enable.
REQ-017 mem_addr  out  13  RAM address.
REQ-018 mem_wdata  out  8  RAM write data.
REQ-019 mem_rdata  in  8  RAM read data, valid the cycle after a mem_en read.
REQ-020 pixel  out  1  registered video pixel.

Function
REQ-021 Active line: Y_START <= vCounter <= Y_START+ACTIVE_LINES-1; display slot k (0..BYTES_PER_LINE-1) SHALL be the cycle with hCounter == X_START-2+8k on an active line.
REQ-022 In a display slot the arbiter SHALL drive mem_en=1, mem_we=0, mem_addr=fetch_addr; display has absolute priority.
REQ-023 fetch_addr SHALL increment by 1 after each display slot and SHALL clear to 0 in the cycle vCounter==0 and hCounter==0 (frame start).
REQ-024 On the edge ending the cycle after a display slot (hCounter == X_START-1+8k), the 8-bit shift register SHALL load mem_rdata; otherwise it SHALL shift left by one, filling 0.
REQ-025 pixel SHALL equal shift-register bit 7, giving byte k bit 7 at hCounter == X_START+8k and bit 0 at X_START+8k+7; pixel SHALL be 0 outside active lines.
REQ-026 CPU FSM states: IDLE, ACCESS, ACK.
REQ-027 IDLE -> ACCESS when cpu_req=1 and the next cycle (hCounter+1, same-line rule, wrap 255->0 ignored since no slot at 0) is not a display slot; otherwise stay IDLE.
REQ-028 On the IDLE->ACCESS transition the FSM SHALL latch cpu_we, cpu_addr and cpu_wdata.
REQ-029 ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values; always -> ACK.
REQ-030 ACK: cpu_ack=1 for exactly one cycle; for reads cpu_rdata SHALL capture mem_rdata; cpu_req is ignored in ACK; always -> IDLE.
REQ-031 Latency: req sampled at cycle C gives ack at C+2, or C+3 if C+1 is a display slot; ACCESS SHALL never coincide with a display slot.
REQ-032 Outside display slots and ACCESS: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Write followed by a read of the same address SHALL return the written data (no write buffering).

Reset
REQ-034 reset SHALL force FSM to IDLE, fetch_addr=0, shift register=0, pixel=0, cpu_ack=0, cpu_rdata=0, mem_en=0, mem_we=0 on the next edge.
REQ-035 reset during ACCESS or ACK SHALL abort the access with no cpu_ack; the CPU re-requests after reset.

Verification
REQ-036 Frame with RAM[0]=0xA5, no CPU: line 36, pixel over hCounter 49..56 = 1,0,1,0,0,1,0,1; mem_addr=0 at hCounter 47.
REQ-037 Full frame: 4608 display reads, addresses 0..4607 in order; fetch_addr back to 0 at the next frame start.
REQ-038 CPU write 0x3C to 0x0100 with req at hCounter 10 on line 100: mem_we at hCounter 11, cpu_ack at 12.
REQ-039 CPU read requested at hCounter 54 on line 40 (55 is slot 1): ACCESS at 56, cpu_ack at 57, cpu_rdata correct, display byte 1 undisturbed.
REQ-040 Back-to-back CPU reads, req held: ack pulses separated by at least 3 cycles; no two mem_en sources ever in the same cycle (assertion).
REQ-041 reset asserted while in ACCESS: no cpu_ack, all outputs at reset values, normal operation on the next frame.
